if_id_hazard_reg: RTL and testbench

- IF/ID pipeline register with an integrated load-use hazard detector and control-hazard flush.
- Sits directly downstream of StageIF. Latches the fetched instruction and PC+4 each cycle.
- Drives pcWrite back to StageIF and a bubble request to the ID control mux.
- Resolves one-cycle load-use stalls and squashes the wrong-path instruction on a taken branch or jump.

---
 rtl/if_id_hazard_reg_if.sv | 29 ++
 rtl/if_id_hazard_reg.sv | 93 +++++++++
 tb/tb_if_id_hazard_reg.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/if_id_hazard_reg_if.sv
// IF/ID register bus: fetch-side inputs, hazard/flush controls and the
// registered ID-side outputs. slave = the IF/ID register, master = its environment.
interface if_id_hazard_reg_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      inInstruction;
    logic [31:0]      inPostPc;
    logic             flushBranch;
    logic             flushJump;
    logic             idExMemRead;
    logic [4:0]       idExRt;
    logic [31:0]      outInstruction;
    logic [31:0]      outPostPc;
    logic             outValid;
    logic             pcWrite;
    logic             bubble;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    modport slave (
        input  inInstruction, inPostPc, flushBranch, flushJump, idExMemRead, idExRt,
        output outInstruction, outPostPc, outValid, pcWrite, bubble, stallCnt, flushCnt
    );

    modport master (
        output inInstruction, inPostPc, flushBranch, flushJump, idExMemRead, idExRt,
        input  outInstruction, outPostPc, outValid, pcWrite, bubble, stallCnt, flushCnt
    );
endinterface

// File: rtl/if_id_hazard_reg.sv
// IF/ID pipeline register with load-use hazard detection and branch/jump flush.
// Optional performance counters are built when IFID_PERF_CNT_EN is defined;
// otherwise stallCnt/flushCnt read constant 0 and no counter flops exist.
module if_id_hazard_reg #(
    parameter logic [31:0] NOP_WORD = 32'h00000000,
    parameter int          CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    if_id_hazard_reg_if.slave   bus
);
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        vld_q, vld_d;

    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic        usesRs, usesRt, hazard, flush;

    // Decode the held instruction and detect a load-use dependency on it
    always_comb begin
        op     = instr_q[31:26];
        rs     = instr_q[25:21];
        rt     = instr_q[20:16];
        usesRs = !(op == 6'h02 || op == 6'h03);
        usesRt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
        flush  = bus.flushBranch | bus.flushJump;
        hazard = vld_q & bus.idExMemRead & (bus.idExRt != 5'd0) &
                 ((usesRs & (rs == bus.idExRt)) | (usesRt & (rt == bus.idExRt)));
    end

    // Next-state: flush beats a stall, a stall holds, otherwise load from IF
    always_comb begin
        instr_d = bus.inInstruction;
        pc_d    = bus.inPostPc;
        vld_d   = 1'b1;
        if (flush) begin
            instr_d = NOP_WORD;
            vld_d   = 1'b0;
        end else if (hazard) begin
            instr_d = instr_q;
            pc_d    = pc_q;
            vld_d   = vld_q;
        end
    end

    // Pipeline register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= NOP_WORD;
            pc_q    <= 32'd0;
            vld_q   <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.outInstruction = instr_q;
    assign bus.outPostPc      = pc_q;
    assign bus.outValid       = vld_q;
    assign bus.pcWrite        = ~(hazard & ~flush);
    assign bus.bubble         = hazard | ~vld_q;

`ifdef IFID_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Counter increments; wrap is the natural modulo of the register width
    always_comb begin
        stall_cnt_d = stall_cnt_q + ((hazard & ~flush) ? CNT_W'(1) : CNT_W'(0));
        flush_cnt_d = flush_cnt_q + (flush ? CNT_W'(1) : CNT_W'(0));
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stallCnt = stall_cnt_q;
    assign bus.flushCnt = flush_cnt_q;
`else
    assign bus.stallCnt = '0;
    assign bus.flushCnt = '0;
`endif
endmodule

// File: tb/tb_if_id_hazard_reg.sv
// Directed bench for if_id_hazard_reg: reset, normal flow, load-use stalls on
// rs and rt, $0 / unused-field cases, flush during stall and counter wrap.
module tb_if_id_hazard_reg;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    if_id_hazard_reg_if #(.CNT_W(CNT_W)) bus ();

    if_id_hazard_reg #(.NOP_WORD(32'h00000000), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // advance one edge; inputs driven and outputs sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
        bus.inInstruction = ins;
        bus.inPostPc      = pc;
        #1;
    endtask

    task automatic chk_regs(input string tag, input logic [31:0] ins,
                            input logic [31:0] pc, input logic v);
        check({tag, ".ins"}, bus.outInstruction, ins);
        check({tag, ".pc"},  bus.outPostPc, pc);
        check({tag, ".vld"}, {31'd0, bus.outValid}, {31'd0, v});
    endtask

    task automatic chk_ctl(input string tag, input logic pw, input logic bb);
        check({tag, ".pcWrite"}, {31'd0, bus.pcWrite}, {31'd0, pw});
        check({tag, ".bubble"},  {31'd0, bus.bubble},  {31'd0, bb});
    endtask

    task automatic chk_cnt(input string tag, input int s, input int f);
`ifdef IFID_PERF_CNT_EN
        check({tag, ".stallCnt"}, 32'(bus.stallCnt), 32'(s));
        check({tag, ".flushCnt"}, 32'(bus.flushCnt), 32'(f));
`else
        check({tag, ".stallCnt"}, 32'(bus.stallCnt), 32'(s * 0));
        check({tag, ".flushCnt"}, 32'(bus.flushCnt), 32'(f * 0));
`endif
    endtask

    initial begin
        reset            = 1'b1;
        bus.flushBranch  = 1'b0;
        bus.flushJump    = 1'b0;
        bus.idExMemRead  = 1'b0;
        bus.idExRt       = 5'd0;
        drive(32'h8C220004, 32'h4);

        // Reset held 2 edges; second edge also carries a flush that must be ignored
        tick();
        bus.flushBranch = 1'b1;
        tick();
        bus.flushBranch = 1'b0;
        #1;
        chk_regs("reset", 32'h0, 32'h0, 1'b0);
        chk_ctl("reset", 1'b1, 1'b1);
        chk_cnt("reset", 0, 0);

        // Normal flow
        reset = 1'b0;
        drive(32'h00221820, 32'h8);
        tick();
        chk_regs("flow1", 32'h00221820, 32'h8, 1'b1);
        chk_ctl("flow1", 1'b1, 1'b0);
        drive(32'h00000000, 32'hC);
        tick();
        chk_regs("flow2", 32'h0, 32'hC, 1'b1);
        chk_ctl("flow2", 1'b1, 1'b0);

        // Load-use on rs (stall #1)
        drive(32'h00432020, 32'h10);
        tick();
        bus.idExMemRead = 1'b1;
        bus.idExRt      = 5'd2;
        drive(32'h8C050000, 32'h14);
        chk_ctl("lu_rs", 1'b0, 1'b1);
        tick();
        chk_regs("lu_rs_hold", 32'h00432020, 32'h10, 1'b1);
        bus.idExMemRead = 1'b0;
        #1;
        chk_ctl("lu_rs_rel", 1'b1, 1'b0);
        tick();
        chk_regs("lu_rs_load", 32'h8C050000, 32'h14, 1'b1);

        // lw rs=0 rt=5: load to $0, and a match on rt of an op that does not read rt
        bus.idExMemRead = 1'b1;
        bus.idExRt      = 5'd0;
        drive(32'h08000010, 32'h18);
        chk_ctl("rt0", 1'b1, 1'b0);
        bus.idExRt = 5'd5;
        #1;
        chk_ctl("lw_rt_unused", 1'b1, 1'b0);
        bus.idExRt = 5'd0;
        #1;
        tick();
        chk_regs("j_load", 32'h08000010, 32'h18, 1'b1);
        chk_ctl("j_rt0", 1'b1, 1'b0);
        drive(32'h08430010, 32'h1C);
        tick();
        bus.idExRt = 5'd2;   // matches the j's rs field, which j does not read
        #1;
        chk_ctl("j_rs_unused", 1'b1, 1'b0);

        // Load-use on rt (stalls #2 and #3)
        bus.idExMemRead = 1'b0;
        drive(32'h00432020, 32'h20);
        tick();
        bus.idExMemRead = 1'b1;
        bus.idExRt      = 5'd3;
        drive(32'h00221820, 32'h24);
        chk_ctl("lu_rt", 1'b0, 1'b1);
        tick();
        chk_regs("lu_rt_hold1", 32'h00432020, 32'h20, 1'b1);
        tick();
        chk_regs("lu_rt_hold2", 32'h00432020, 32'h20, 1'b1);

        // Flush during stall: flush wins and pcWrite is released
        bus.flushBranch = 1'b1;
        #1;
        chk_ctl("fl_stall", 1'b1, 1'b1);
        tick();
        bus.flushBranch = 1'b0;
        #1;
        chk_regs("fl_nop", 32'h0, 32'h24, 1'b0);
        chk_ctl("fl_after", 1'b1, 1'b1);
        drive(32'h00221820, 32'h28);
        tick();
        chk_regs("fl_nohold", 32'h00221820, 32'h28, 1'b1);

        // Both flush sources together count as a single flush
        bus.idExMemRead = 1'b0;
        bus.flushBranch = 1'b1;
        bus.flushJump   = 1'b1;
        drive(32'h00432020, 32'h2C);
        tick();
        bus.flushBranch = 1'b0;
        bus.flushJump   = 1'b0;
        #1;
        chk_regs("fl_both", 32'h0, 32'h2C, 1'b0);
        chk_cnt("cnt", 3, 2);

        // 16 more flushes wrap the 4-bit flush counter back to 2
        bus.flushJump = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        bus.flushJump = 1'b0;
        #1;
        chk_cnt("cnt_wrap", 3, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
